bp_update_sched: RTL and testbench

Write-port scheduler for the agree branch predictor tables (BTB and PHT). It sits between the branch commit stage and the tables. It buffers commit-stage updates in a small FIFO and issues at most one table write per cycle. It also runs a full-table initialisation sweep after reset and on every flush, holding new updates until the sweep finishes.

---
 rtl/bp_update_sched.sv | 213 +++++++++++++++++++++
 tb/tb_bp_update_sched.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_update_sched.sv
// Write-port scheduler for the agree predictor tables (BTB and PHT).
// Commit-stage jump updates are queued in a small FIFO and issued to the
// tables at most one per cycle. After reset and on every flush, a full-table
// clear/init sweep runs first, and queued updates wait until it completes.
module bp_update_sched #(
  parameter int INDEX_WIDTH   = 8,
  parameter int HISTORY_WIDTH = 8,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        flush_i,
  input  logic                        upd_valid_i,
  input  logic                        upd_is_jmp_i,
  input  logic                        upd_btb_hit_i,
  input  logic                        upd_taken_i,
  input  logic                        upd_bias_i,
  input  logic [INDEX_WIDTH-1:0]      upd_btb_index_i,
  input  logic [32-INDEX_WIDTH-3:0]   upd_tag_i,
  input  logic [31:0]                 upd_target_i,
  input  logic [HISTORY_WIDTH-1:0]    upd_pht_index_i,
  output logic                        upd_ready_o,
  output logic                        btb_wren_o,
  output logic                        btb_clr_o,
  output logic [INDEX_WIDTH-1:0]      btb_wr_index_o,
  output logic [32-INDEX_WIDTH-3:0]   btb_wr_tag_o,
  output logic [31:0]                 btb_wr_target_o,
  output logic                        btb_wr_taken_o,
  output logic                        pht_wren_o,
  output logic                        pht_init_o,
  output logic [HISTORY_WIDTH-1:0]    pht_wr_index_o,
  output logic                        pht_agree_o,
  output logic                        busy_o,
  output logic [15:0]                 drop_cnt_o
);

  localparam int TAG_WIDTH = 32 - INDEX_WIDTH - 2;
  localparam int SW        = (INDEX_WIDTH > HISTORY_WIDTH) ? INDEX_WIDTH : HISTORY_WIDTH;
  localparam int PTR_W     = $clog2(FIFO_DEPTH);

  typedef enum logic {
    SWEEP = 1'b0,
    IDLE  = 1'b1
  } state_t;

  typedef struct packed {
    logic                     btb_hit;
    logic                     taken;
    logic                     bias;
    logic [INDEX_WIDTH-1:0]   btb_index;
    logic [TAG_WIDTH-1:0]     tag;
    logic [31:0]              target;
    logic [HISTORY_WIDTH-1:0] pht_index;
  } entry_t;

  state_t                   r_state;
  logic [SW-1:0]            r_idx;
  logic [PTR_W:0]           r_wr_ptr;
  logic [PTR_W:0]           r_rd_ptr;
  entry_t                   r_mem [FIFO_DEPTH];
  logic [15:0]              r_drop_cnt;

  logic                     r_btb_wren;
  logic                     r_btb_clr;
  logic [INDEX_WIDTH-1:0]   r_btb_wr_index;
  logic [TAG_WIDTH-1:0]     r_btb_wr_tag;
  logic [31:0]              r_btb_wr_target;
  logic                     r_btb_wr_taken;
  logic                     r_pht_wren;
  logic                     r_pht_init;
  logic [HISTORY_WIDTH-1:0] r_pht_wr_index;
  logic                     r_pht_agree;
  logic                     r_busy;

  logic                     w_full;
  logic                     w_empty;
  logic                     w_jmp_req;
  logic                     w_push;
  logic                     w_drop;
  logic                     w_pop;
  logic                     w_sweeping;
  logic [SW-1:0]            w_sweep_idx;
  logic                     w_btb_in_range;
  logic                     w_pht_in_range;
  entry_t                   w_new;
  entry_t                   w_head;

  // Pointers carry one extra bit so equal low bits can mean either empty or full.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                   (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);

  // A flush discards same-cycle updates outright; they are neither queued nor dropped.
  assign w_jmp_req = upd_valid_i & upd_is_jmp_i & ~flush_i;
  assign w_push    = w_jmp_req & ~w_full;
  assign w_drop    = w_jmp_req & w_full;

  // A flush emits sweep index 0 immediately, so the restart is visible the next cycle.
  assign w_sweeping  = flush_i | (r_state == SWEEP);
  assign w_sweep_idx = flush_i ? '0 : r_idx;
  assign w_pop       = ~w_sweeping & ~w_empty;

  // The narrower table only takes writes while the sweep index is within its range.
  assign w_btb_in_range = ((w_sweep_idx >> INDEX_WIDTH) == '0);
  assign w_pht_in_range = ((w_sweep_idx >> HISTORY_WIDTH) == '0);

  assign w_new = '{
    btb_hit:   upd_btb_hit_i,
    taken:     upd_taken_i,
    bias:      upd_bias_i,
    btb_index: upd_btb_index_i,
    tag:       upd_tag_i,
    target:    upd_target_i,
    pht_index: upd_pht_index_i
  };
  assign w_head = r_mem[r_rd_ptr[PTR_W-1:0]];

  // FIFO storage: written on push only.
  // NOTE: the entry array has no reset; validity is tracked by the pointers alone,
  // which keeps the storage a plain register file without a reset network.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr[PTR_W-1:0]] <= w_new;
    end
  end

  // FIFO pointers and saturating drop counter.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (flush_i) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  // Sweep/issue FSM with registered table-write outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state         <= SWEEP;
      r_idx           <= '0;
      r_btb_wren      <= 1'b0;
      r_btb_clr       <= 1'b0;
      r_btb_wr_index  <= '0;
      r_btb_wr_tag    <= '0;
      r_btb_wr_target <= '0;
      r_btb_wr_taken  <= 1'b0;
      r_pht_wren      <= 1'b0;
      r_pht_init      <= 1'b0;
      r_pht_wr_index  <= '0;
      r_pht_agree     <= 1'b0;
      r_busy          <= 1'b1;
    end else begin
      r_btb_wren <= 1'b0;
      r_btb_clr  <= 1'b0;
      r_pht_wren <= 1'b0;
      r_pht_init <= 1'b0;
      if (w_sweeping) begin
        r_busy         <= 1'b1;
        r_btb_clr      <= w_btb_in_range;
        r_btb_wr_index <= w_sweep_idx[INDEX_WIDTH-1:0];
        r_pht_init     <= w_pht_in_range;
        r_pht_wr_index <= w_sweep_idx[HISTORY_WIDTH-1:0];
        if (w_sweep_idx == '1) begin
          r_state <= IDLE;
          r_idx   <= '0;
        end else begin
          r_state <= SWEEP;
          r_idx   <= w_sweep_idx + 1'b1;
        end
      end else begin
        r_busy <= 1'b0;
        if (w_pop) begin
          r_btb_wren      <= ~w_head.btb_hit;
          r_btb_wr_index  <= w_head.btb_index;
          r_btb_wr_tag    <= w_head.tag;
          r_btb_wr_target <= w_head.target;
          r_btb_wr_taken  <= w_head.taken;
          r_pht_wren      <= 1'b1;
          r_pht_wr_index  <= w_head.pht_index;
          r_pht_agree     <= w_head.taken ~^ w_head.bias;
        end
      end
    end
  end

  assign upd_ready_o     = ~w_full;
  assign btb_wren_o      = r_btb_wren;
  assign btb_clr_o       = r_btb_clr;
  assign btb_wr_index_o  = r_btb_wr_index;
  assign btb_wr_tag_o    = r_btb_wr_tag;
  assign btb_wr_target_o = r_btb_wr_target;
  assign btb_wr_taken_o  = r_btb_wr_taken;
  assign pht_wren_o      = r_pht_wren;
  assign pht_init_o      = r_pht_init;
  assign pht_wr_index_o  = r_pht_wr_index;
  assign pht_agree_o     = r_pht_agree;
  assign busy_o          = r_busy;
  assign drop_cnt_o      = r_drop_cnt;

endmodule

// File: tb/tb_bp_update_sched.sv
// Self-checking bench for bp_update_sched: a queue-based behavioural model
// predicts every registered output each cycle, and directed scenarios pin the
// model with hand-computed literal expectations.
module tb_bp_update_sched;

  localparam int IW    = 4;
  localparam int HW    = 3;
  localparam int DEPTH = 4;
  localparam int TW    = 32 - IW - 2;
  localparam int NSWP  = 16;  // 2^max(IW,HW)

  logic          clk;
  logic          rst_ni;
  logic          flush_i;
  logic          upd_valid_i;
  logic          upd_is_jmp_i;
  logic          upd_btb_hit_i;
  logic          upd_taken_i;
  logic          upd_bias_i;
  logic [IW-1:0] upd_btb_index_i;
  logic [TW-1:0] upd_tag_i;
  logic [31:0]   upd_target_i;
  logic [HW-1:0] upd_pht_index_i;
  logic          upd_ready_o;
  logic          btb_wren_o;
  logic          btb_clr_o;
  logic [IW-1:0] btb_wr_index_o;
  logic [TW-1:0] btb_wr_tag_o;
  logic [31:0]   btb_wr_target_o;
  logic          btb_wr_taken_o;
  logic          pht_wren_o;
  logic          pht_init_o;
  logic [HW-1:0] pht_wr_index_o;
  logic          pht_agree_o;
  logic          busy_o;
  logic [15:0]   drop_cnt_o;

  bp_update_sched #(
    .INDEX_WIDTH  (IW),
    .HISTORY_WIDTH(HW),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .flush_i        (flush_i),
    .upd_valid_i    (upd_valid_i),
    .upd_is_jmp_i   (upd_is_jmp_i),
    .upd_btb_hit_i  (upd_btb_hit_i),
    .upd_taken_i    (upd_taken_i),
    .upd_bias_i     (upd_bias_i),
    .upd_btb_index_i(upd_btb_index_i),
    .upd_tag_i      (upd_tag_i),
    .upd_target_i   (upd_target_i),
    .upd_pht_index_i(upd_pht_index_i),
    .upd_ready_o    (upd_ready_o),
    .btb_wren_o     (btb_wren_o),
    .btb_clr_o      (btb_clr_o),
    .btb_wr_index_o (btb_wr_index_o),
    .btb_wr_tag_o   (btb_wr_tag_o),
    .btb_wr_target_o(btb_wr_target_o),
    .btb_wr_taken_o (btb_wr_taken_o),
    .pht_wren_o     (pht_wren_o),
    .pht_init_o     (pht_init_o),
    .pht_wr_index_o (pht_wr_index_o),
    .pht_agree_o    (pht_agree_o),
    .busy_o         (busy_o),
    .drop_cnt_o     (drop_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  typedef struct {
    bit          hit;
    bit          taken;
    bit          bias;
    bit [IW-1:0] bidx;
    bit [TW-1:0] tag;
    bit [31:0]   tgt;
    bit [HW-1:0] pidx;
  } ent_t;

  ent_t        m_q[$];
  ent_t        m_pending;
  ent_t        m_head;
  bit          m_do_push;
  bit          m_valid = 0;
  bit          m_in_sweep;
  int          m_pos;
  int unsigned m_drop;

  bit          e_in_reset;
  bit          e_btb_wren, e_btb_clr, e_pht_wren, e_pht_init, e_busy;
  bit [IW-1:0] e_btb_idx;
  bit [TW-1:0] e_tag;
  bit [31:0]   e_tgt;
  bit          e_taken;
  bit [HW-1:0] e_pht_idx;
  bit          e_agree;

  // Predicts the outputs registered at each rising edge from the table rules.
  always @(posedge clk) begin
    m_valid = 1;
    e_btb_wren = 0; e_btb_clr = 0; e_pht_wren = 0; e_pht_init = 0;
    if (!rst_ni) begin
      m_q.delete();
      m_drop = 0; m_pos = 0; m_in_sweep = 1;
      e_in_reset = 1; e_busy = 1;
      e_btb_idx = 0; e_tag = 0; e_tgt = 0; e_taken = 0; e_pht_idx = 0; e_agree = 0;
    end else begin
      e_in_reset = 0;
      m_do_push = 0;
      if (flush_i) begin
        m_q.delete();
        m_pos = 0;
        m_in_sweep = 1;
      end else if (upd_valid_i && upd_is_jmp_i) begin
        if (m_q.size() == DEPTH) begin
          if (m_drop < 32'hFFFF) m_drop++;
        end else begin
          m_do_push = 1;
          m_pending.hit   = upd_btb_hit_i;
          m_pending.taken = upd_taken_i;
          m_pending.bias  = upd_bias_i;
          m_pending.bidx  = upd_btb_index_i;
          m_pending.tag   = upd_tag_i;
          m_pending.tgt   = upd_target_i;
          m_pending.pidx  = upd_pht_index_i;
        end
      end
      if (m_in_sweep) begin
        e_busy     = 1;
        e_btb_clr  = (m_pos < (1 << IW));
        e_btb_idx  = IW'(m_pos % (1 << IW));
        e_pht_init = (m_pos < (1 << HW));
        e_pht_idx  = HW'(m_pos % (1 << HW));
        m_pos++;
        if (m_pos == NSWP) m_in_sweep = 0;
      end else begin
        e_busy = 0;
        if (m_q.size() > 0) begin
          m_head     = m_q.pop_front();
          e_btb_wren = !m_head.hit;
          e_btb_idx  = m_head.bidx;
          e_tag      = m_head.tag;
          e_tgt      = m_head.tgt;
          e_taken    = m_head.taken;
          e_pht_wren = 1;
          e_pht_idx  = m_head.pidx;
          e_agree    = (m_head.taken == m_head.bias);
        end
      end
      if (m_do_push) m_q.push_back(m_pending);
    end
  end

  // Compares every DUT output against the model mid-cycle.
  always @(negedge clk) begin
    if (m_valid) begin
      check("busy", busy_o, e_busy);
      check("upd_ready", upd_ready_o, (m_q.size() < DEPTH));
      check("drop_cnt", drop_cnt_o, m_drop);
      check("btb_wren", btb_wren_o, e_btb_wren);
      check("btb_clr", btb_clr_o, e_btb_clr);
      check("pht_wren", pht_wren_o, e_pht_wren);
      check("pht_init", pht_init_o, e_pht_init);
      if (e_in_reset) begin
        check("rst_btb_idx", btb_wr_index_o, 0);
        check("rst_tag", btb_wr_tag_o, 0);
        check("rst_target", btb_wr_target_o, 0);
        check("rst_taken", btb_wr_taken_o, 0);
        check("rst_pht_idx", pht_wr_index_o, 0);
        check("rst_agree", pht_agree_o, 0);
      end else begin
        if (e_btb_clr || e_btb_wren) check("btb_idx", btb_wr_index_o, e_btb_idx);
        if (e_btb_wren) begin
          check("btb_tag", btb_wr_tag_o, e_tag);
          check("btb_target", btb_wr_target_o, e_tgt);
          check("btb_taken", btb_wr_taken_o, e_taken);
        end
        if (e_pht_init || e_pht_wren) check("pht_idx", pht_wr_index_o, e_pht_idx);
        if (e_pht_wren) check("pht_agree", pht_agree_o, e_agree);
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic idle_in();
    flush_i = 0; upd_valid_i = 0; upd_is_jmp_i = 0; upd_btb_hit_i = 0;
    upd_taken_i = 0; upd_bias_i = 0; upd_btb_index_i = '0; upd_tag_i = '0;
    upd_target_i = '0; upd_pht_index_i = '0;
  endtask

  task automatic set_upd(input bit jmp, input bit hit, input bit taken, input bit bias,
                         input int bidx, input int pidx, input logic [31:0] tgt);
    upd_valid_i = 1; upd_is_jmp_i = jmp; upd_btb_hit_i = hit;
    upd_taken_i = taken; upd_bias_i = bias;
    upd_btb_index_i = IW'(bidx); upd_pht_index_i = HW'(pidx);
    upd_tag_i = TW'(tgt >> 4); upd_target_i = tgt;
  endtask

  int  cnt;
  bit  seen;

  initial begin
    idle_in();
    rst_ni = 0;
    repeat (3) @(negedge clk);
    check("lit_rst_busy", busy_o, 1);
    check("lit_rst_ready", upd_ready_o, 1);
    check("lit_rst_drop", drop_cnt_o, 0);
    check("lit_rst_clr", btb_clr_o, 0);

    // Reset sweep: 16 BTB clears, PHT inits only in the first 8.
    rst_ni = 1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("lit_sweep_clr", btb_clr_o, 1);
      check("lit_sweep_idx", btb_wr_index_o, i);
      check("lit_sweep_init", pht_init_o, (i < 8));
      if (i < 8) check("lit_sweep_pidx", pht_wr_index_o, i);
      check("lit_sweep_busy", busy_o, 1);
    end
    @(negedge clk);
    check("lit_busy_fall", busy_o, 0);
    check("lit_clr_end", btb_clr_o, 0);

    // Single update, two-cycle latency.
    set_upd(1, 0, 1, 0, 5, 3, 32'h0000_4440);
    @(negedge clk);
    idle_in();
    check("lit_lat_early", pht_wren_o, 0);
    @(negedge clk);
    check("lit_upd_wren", btb_wren_o, 1);
    check("lit_upd_idx", btb_wr_index_o, 5);
    check("lit_upd_pwren", pht_wren_o, 1);
    check("lit_upd_pidx", pht_wr_index_o, 3);
    check("lit_upd_agree", pht_agree_o, 0);

    // BTB hit: PHT only.
    set_upd(1, 1, 1, 0, 5, 3, 32'h0000_4440);
    @(negedge clk);
    idle_in();
    @(negedge clk);
    check("lit_hit_wren", btb_wren_o, 0);
    check("lit_hit_pwren", pht_wren_o, 1);

    // Non-jump: ignored.
    set_upd(0, 0, 1, 1, 7, 1, 32'h0000_1230);
    @(negedge clk);
    idle_in();
    @(negedge clk);
    check("lit_nj_wren", btb_wren_o, 0);
    check("lit_nj_pwren", pht_wren_o, 0);
    check("lit_nj_drop", drop_cnt_o, 0);

    // Overfill the FIFO during a sweep.
    flush_i = 1;
    @(negedge clk);
    idle_in();
    for (int i = 0; i < 6; i++) begin
      set_upd(1, 0, i[0], 0, i + 1, i, 32'h1000 + 32'(i) * 4);
      @(negedge clk);
      if (i == 3) check("lit_full_ready", upd_ready_o, 0);
    end
    idle_in();
    check("lit_drop2", drop_cnt_o, 2);
    seen = 0;
    for (int t = 0; t < 40 && !seen; t++) begin
      if (!busy_o) seen = 1;
      else @(negedge clk);
    end
    check("lit_busy_wait", seen, 1);
    for (int i = 0; i < 4; i++) begin
      check("lit_order_wren", btb_wren_o, 1);
      check("lit_order_tgt", btb_wr_target_o, 32'h1000 + 32'(i) * 4);
      @(negedge clk);
    end
    check("lit_order_done", pht_wren_o, 0);

    // Flush at sweep index 9 with two queued entries and a same-cycle update.
    flush_i = 1;
    @(negedge clk);
    idle_in();
    for (int i = 0; i < 2; i++) begin
      set_upd(1, 0, 1, 1, 9, 2, 32'h2000 + 32'(i) * 4);
      @(negedge clk);
    end
    idle_in();
    seen = 0;
    for (int t = 0; t < 20 && !seen; t++) begin
      if (btb_clr_o && btb_wr_index_o == 4'd9) seen = 1;
      else @(negedge clk);
    end
    check("lit_idx9_wait", seen, 1);
    flush_i = 1;
    set_upd(1, 0, 1, 1, 3, 3, 32'h3000);
    @(negedge clk);
    idle_in();
    check("lit_restart_clr", btb_clr_o, 1);
    check("lit_restart_idx", btb_wr_index_o, 0);
    check("lit_restart_ready", upd_ready_o, 1);
    check("lit_restart_drop", drop_cnt_o, 2);
    cnt = 1;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (busy_o) cnt++;
      else break;
    end
    check("lit_restart_len", cnt, 16);
    for (int t = 0; t < 3; t++) begin
      check("lit_discard", btb_wren_o | pht_wren_o, 0);
      @(negedge clk);
    end

    // Randomized traffic with occasional flushes and one mid-run reset.
    for (int c = 0; c < 3000; c++) begin
      rst_ni          = !(c >= 1500 && c < 1503);
      flush_i         = ($urandom_range(0, 63) == 0);
      upd_valid_i     = ($urandom_range(0, 3) != 0);
      upd_is_jmp_i    = ($urandom_range(0, 4) != 0);
      upd_btb_hit_i   = $urandom_range(0, 1);
      upd_taken_i     = $urandom_range(0, 1);
      upd_bias_i      = $urandom_range(0, 1);
      upd_btb_index_i = IW'($urandom);
      upd_tag_i       = TW'($urandom);
      upd_target_i    = $urandom;
      upd_pht_index_i = HW'($urandom);
      @(negedge clk);
    end
    idle_in();
    rst_ni = 1;
    repeat (30) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
